imm_target_pipe: RTL

//  Parametrised, pipelined successor to the single-cycle immediate generator. Decodes all RV

---
 rtl/imm_target_pipe.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/imm_target_pipe.sv
`default_nettype none
// ============================================================================
// Module  : imm_target_pipe
// Brief   : Pipelined RV immediate decoder and control-transfer target unit
// Revision: 1.0 - initial release
// ============================================================================
module imm_target_pipe #(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 2,
  parameter bit C_EXT       = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [2:0]      immsel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic            out_misalign,
  output logic            out_illegal
);

  localparam logic [2:0] c_SEL_I    = 3'd0;
  localparam logic [2:0] c_SEL_S    = 3'd1;
  localparam logic [2:0] c_SEL_B    = 3'd2;
  localparam logic [2:0] c_SEL_U    = 3'd3;
  localparam logic [2:0] c_SEL_J    = 3'd4;
  localparam logic [2:0] c_SEL_JALR = 3'd5;
  localparam logic [2:0] c_SEL_ZIMM = 3'd6;

  if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
    $error("imm_target_pipe: XLEN must be 32 or 64");
  end
  if ((PIPE_STAGES != 1) && (PIPE_STAGES != 2)) begin : g_bad_stages
    $error("imm_target_pipe: PIPE_STAGES must be 1 or 2");
  end

  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]    w_dec_imm;
  logic [XLEN-1:0]    w_dec_base;
  logic               w_dec_jalr;
  logic               w_dec_ctrl;
  logic               w_dec_ill;

  logic               out_valid_q;
  logic [XLEN-1:0]    out_imm_q;
  logic [XLEN-1:0]    out_target_q;
  logic               out_misalign_q;
  logic               out_illegal_q;

  // Reserved selector yields imm=0 and base=pc, so the target naturally equals pc.
  always_comb begin
    w_imm32    = '0;
    w_dec_jalr = 1'b0;
    w_dec_ctrl = 1'b0;
    w_dec_ill  = 1'b0;
    case (immsel)
      c_SEL_I:    w_imm32 = {{20{inst[31]}}, inst[31:20]};
      c_SEL_S:    w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      c_SEL_B: begin
        w_imm32    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        w_dec_ctrl = 1'b1;
      end
      c_SEL_U:    w_imm32 = {inst[31:12], 12'b0};
      c_SEL_J: begin
        w_imm32    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        w_dec_ctrl = 1'b1;
      end
      c_SEL_JALR: begin
        w_imm32    = {{20{inst[31]}}, inst[31:20]};
        w_dec_jalr = 1'b1;
        w_dec_ctrl = 1'b1;
      end
      c_SEL_ZIMM: w_imm32 = {27'b0, inst[19:15]};
      default:    w_dec_ill = 1'b1;
    endcase
  end

  assign w_dec_imm  = XLEN'(w_imm32);
  assign w_dec_base = w_dec_jalr ? rs1 : pc;

  function automatic logic [XLEN-1:0] f_target(input logic [XLEN-1:0] base,
                                               input logic [XLEN-1:0] imm,
                                               input logic            jalr);
    logic [XLEN-1:0] sum;
    sum = base + imm;
    if (jalr) sum[0] = 1'b0;
    return sum;
  endfunction

  function automatic logic f_misalign(input logic [XLEN-1:0] tgt, input logic ctrl);
    return ctrl && (C_EXT == 1'b0) && tgt[1];
  endfunction

  if (PIPE_STAGES == 1) begin : g_one_stage
    logic            w_out_load;
    logic            w_accept;
    logic [XLEN-1:0] tgt_d;

    assign w_out_load = !out_valid_q || out_ready;
    assign in_ready   = !flush && w_out_load;
    assign w_accept   = in_ready && in_valid;
    assign tgt_d      = f_target(w_dec_base, w_dec_imm, w_dec_jalr);

    always_ff @(posedge clk) begin
      if (reset) begin
        out_valid_q    <= 1'b0;
        out_imm_q      <= '0;
        out_target_q   <= '0;
        out_misalign_q <= 1'b0;
        out_illegal_q  <= 1'b0;
      end else begin
        if (flush) out_valid_q <= 1'b0;
        else if (w_out_load) out_valid_q <= in_valid;
        if (w_accept) begin
          out_imm_q      <= w_dec_imm;
          out_target_q   <= tgt_d;
          out_misalign_q <= f_misalign(tgt_d, w_dec_ctrl);
          out_illegal_q  <= w_dec_ill;
        end
      end
    end
  end else begin : g_two_stage
    logic            s1_valid_q;
    logic [XLEN-1:0] s1_imm_q;
    logic [XLEN-1:0] s1_base_q;
    logic            s1_jalr_q;
    logic            s1_ctrl_q;
    logic            s1_ill_q;
    logic            w_out_load;
    logic            w_s1_drain;
    logic            w_accept;
    logic [XLEN-1:0] tgt_d;

    // Stage 1 may refill in the same cycle it hands its entry onward.
    assign w_out_load = !out_valid_q || out_ready;
    assign w_s1_drain = s1_valid_q && w_out_load;
    assign in_ready   = !flush && (!s1_valid_q || w_s1_drain);
    assign w_accept   = in_ready && in_valid;
    assign tgt_d      = f_target(s1_base_q, s1_imm_q, s1_jalr_q);

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_valid_q     <= 1'b0;
        s1_imm_q       <= '0;
        s1_base_q      <= '0;
        s1_jalr_q      <= 1'b0;
        s1_ctrl_q      <= 1'b0;
        s1_ill_q       <= 1'b0;
        out_valid_q    <= 1'b0;
        out_imm_q      <= '0;
        out_target_q   <= '0;
        out_misalign_q <= 1'b0;
        out_illegal_q  <= 1'b0;
      end else begin
        if (flush) begin
          s1_valid_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end else begin
          if (!s1_valid_q || w_s1_drain) s1_valid_q <= in_valid;
          if (w_out_load) out_valid_q <= s1_valid_q;
        end
        if (w_accept) begin
          s1_imm_q  <= w_dec_imm;
          s1_base_q <= w_dec_base;
          s1_jalr_q <= w_dec_jalr;
          s1_ctrl_q <= w_dec_ctrl;
          s1_ill_q  <= w_dec_ill;
        end
        if (w_s1_drain) begin
          out_imm_q      <= s1_imm_q;
          out_target_q   <= tgt_d;
          out_misalign_q <= f_misalign(tgt_d, s1_ctrl_q);
          out_illegal_q  <= s1_ill_q;
        end
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_imm      = out_imm_q;
  assign out_target   = out_target_q;
  assign out_misalign = out_misalign_q;
  assign out_illegal  = out_illegal_q;

endmodule
`default_nettype wire
